// File: rtl/dff_pkg.sv
`default_nettype none
// ============================================================================
// dff_pkg : shared defaults and count-width helper for the register pipelines
// Revision: 1.0
// ============================================================================
package dff_pkg;

    localparam int DEFAULT_RESET_VAL = 0;

    // Bits needed to hold a count from 0 up to and including depth.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_stage.sv
`default_nettype none
// ============================================================================
// dff_stage : one data+valid register with async reset, sync clear and enable
// Revision: 1.0
// ============================================================================
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= RESET_VAL;
            r_valid <= 1'b0;
        end else if (sync_clr) begin
            r_data  <= RESET_VAL;
            r_valid <= 1'b0;
        end else if (en) begin
            r_data  <= d;
            r_valid <= d_valid;
        end
    end

    assign q       = r_data;
    assign q_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
// dff_pipe : WIDTH x DEPTH delay line with per-stage valid and occupancy count
// Revision: 1.0
// ============================================================================
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          sync_clr,
    input  logic [WIDTH-1:0]              d,
    input  logic                          d_valid,
    output logic [WIDTH-1:0]              q,
    output logic                          q_valid,
    output logic [WIDTH*DEPTH-1:0]        taps,
    output logic [DEPTH-1:0]              tap_valid,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);

    // Slot 0 of each chain is the pipeline input; slot i+1 is the output of stage i.
    logic [WIDTH*(DEPTH+1)-1:0] w_dchain;
    logic [DEPTH:0]             w_vchain;
    logic [CW-1:0]              r_count;

    assign w_dchain[WIDTH-1:0] = d;
    assign w_vchain[0]         = d_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .sync_clr (sync_clr),
            .d        (w_dchain[i*WIDTH +: WIDTH]),
            .d_valid  (w_vchain[i]),
            .q        (w_dchain[(i+1)*WIDTH +: WIDTH]),
            .q_valid  (w_vchain[i+1])
        );
    end

    // Modular arithmetic keeps the transient +1 harmless even when DEPTH+1 is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (sync_clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CW'(d_valid) - CW'(w_vchain[DEPTH]);
        end
    end

    assign taps      = w_dchain[WIDTH*(DEPTH+1)-1:WIDTH];
    assign tap_valid = w_vchain[DEPTH:1];
    assign q         = w_dchain[WIDTH*DEPTH +: WIDTH];
    assign q_valid   = w_vchain[DEPTH];
    assign count     = r_count;

    a_count_matches_valids : assert property (
        @(posedge clk) disable iff (!reset)
        r_count == CW'($countones(w_vchain[DEPTH:1]))
    );

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// ============================================================================
// tb_dff_pipe : directed + random bench with output scoreboard for dff_pipe
// Revision: 1.0
// ============================================================================
module tb_dff_pipe;

    localparam int               WIDTH = 8;
    localparam int               DEPTH = 4;
    localparam logic [WIDTH-1:0] RV    = 8'hA5;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   en;
    logic                   sync_clr;
    logic [WIDTH-1:0]       d;
    logic                   d_valid;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic [WIDTH*DEPTH-1:0] taps;
    logic [DEPTH-1:0]       tap_valid;
    logic [2:0]             count;

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    dff_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sync_clr  (sync_clr),
        .d         (d),
        .d_valid   (d_valid),
        .q         (q),
        .q_valid   (q_valid),
        .taps      (taps),
        .tap_valid (tap_valid),
        .count     (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge, record the expected output, return at posedge+1.
    task automatic step(input logic e, input logic c, input logic [WIDTH-1:0] dd, input logic dv);
        @(negedge clk);
        en = e; sync_clr = c; d = dd; d_valid = dv;
        if (c)            exp_q.delete();
        else if (e && dv) exp_q.push_back(dd);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each new valid output and tracks occupancy.
    initial begin : monitor
        logic             s_rst, s_en, s_clr, s_dv;
        logic [DEPTH-1:0] mvalid;
        logic [WIDTH-1:0] expd;
        mvalid = '0;
        forever begin
            @(posedge clk);
            s_rst = reset; s_en = en; s_clr = sync_clr; s_dv = d_valid;
            #1;
            if (s_rst !== 1'b1 || reset !== 1'b1 || s_clr) begin
                mvalid = '0;
            end else if (s_en) begin
                mvalid = {mvalid[DEPTH-2:0], s_dv};
                if (q_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_output", {24'd0, q}, 32'hFFFF_FFFF);
                    end else begin
                        expd = exp_q.pop_front();
                        chk("sb_q", {24'd0, q}, {24'd0, expd});
                    end
                end
            end
            chk("mon_tap_valid", {28'd0, tap_valid}, {28'd0, mvalid});
            chk("mon_count_popcount", {29'd0, count}, 32'($countones(tap_valid)));
        end
    end

    initial begin : watchdog
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : stimulus
        logic [7:0] bub_d   [8];
        logic       bub_v   [8];
        logic [2:0] bub_cnt [8];
        logic [7:0] rd;

        bub_d   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h12, 8'h13};
        bub_v   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bub_cnt = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};

        reset = 1'b0; en = 1'b0; sync_clr = 1'b0; d = '0; d_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q",         {24'd0, q},         {24'd0, RV});
        chk("rst_q_valid",   {31'd0, q_valid},   32'd0);
        chk("rst_taps",      taps,               32'hA5A5_A5A5);
        chk("rst_tap_valid", {28'd0, tap_valid}, 32'd0);
        chk("rst_count",     {29'd0, count},     32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Streaming 01..05, then drain.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'(i + 1), 1'b1);
            chk("stream_count", {29'd0, count}, (i < 4) ? 32'(i + 1) : 32'd4);
            if (i >= 3) begin
                chk("stream_q",       {24'd0, q},       32'(i - 2));
                chk("stream_q_valid", {31'd0, q_valid}, 32'd1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            chk("drain_count", {29'd0, count}, 32'(3 - i));
            if (i < 3) chk("drain_q", {24'd0, q}, 32'(i + 3));
        end
        chk("drain_q_valid", {31'd0, q_valid}, 32'd0);

        // Stall with two samples inside.
        step(1'b1, 1'b0, 8'h10, 1'b1);
        step(1'b1, 1'b0, 8'h11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'(8'h70 + i), 1'b1);
            chk("stall_taps",      taps,               32'h0000_1011);
            chk("stall_tap_valid", {28'd0, tap_valid}, 32'h3);
            chk("stall_count",     {29'd0, count},     32'd2);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("resume1_taps",    taps,             32'h0010_1100);
        chk("resume1_q_valid", {31'd0, q_valid}, 32'd0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("resume2_q",       {24'd0, q},       32'h10);
        chk("resume2_q_valid", {31'd0, q_valid}, 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("resume3_q",       {24'd0, q},       32'h11);
        chk("resume3_count",   {29'd0, count},   32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("resume4_q_valid", {31'd0, q_valid}, 32'd0);

        // Bubbles: data shifts ungated, valid pattern follows.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, bub_d[i], bub_v[i]);
            chk("bubble_count", {29'd0, count}, {29'd0, bub_cnt[i]});
            if (i >= 3) begin
                chk("bubble_q",       {24'd0, q},       {24'd0, bub_d[i-3]});
                chk("bubble_q_valid", {31'd0, q_valid}, {31'd0, bub_v[i-3]});
            end
        end

        // Flush with en=1 and d_valid=1 while full.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h21 + i), 1'b1);
        chk("full_taps",  taps,           32'h2122_2324);
        chk("full_count", {29'd0, count}, 32'd4);
        step(1'b1, 1'b1, 8'h99, 1'b1);
        chk("flush_taps",      taps,               32'hA5A5_A5A5);
        chk("flush_tap_valid", {28'd0, tap_valid}, 32'd0);
        chk("flush_count",     {29'd0, count},     32'd0);
        step(1'b1, 1'b0, 8'h31, 1'b1);
        step(1'b1, 1'b0, 8'h32, 1'b1);
        step(1'b0, 1'b1, 8'h55, 1'b1);
        chk("flush_noen_taps",  taps,           32'hA5A5_A5A5);
        chk("flush_noen_count", {29'd0, count}, 32'd0);

        // Asynchronous reset asserted between edges.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b1);
        en = 1'b0;
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_q",         {24'd0, q},         {24'd0, RV});
        chk("async_rst_taps",      taps,               32'hA5A5_A5A5);
        chk("async_rst_tap_valid", {28'd0, tap_valid}, 32'd0);
        chk("async_rst_count",     {29'd0, count},     32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Random traffic; the monitor checks every edge.
        for (int i = 0; i < 1000; i++) begin
            rd = 8'($urandom);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), rd, 1'($urandom));
        end
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_count",            {29'd0, count},   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
